// File: rtl/idli_sqi_fetch_m.sv
// rtl/idli_sqi_fetch_m.sv - nibble-serial PC capture, SQI instruction read, one-entry decode buffer
module idli_sqi_fetch_m (
  input  logic        i_pc_gck,
  input  logic        i_pc_rst_n,
  input  logic [3:0]  i_fe_pc,
  output logic        o_fe_pc_inc,
  input  logic        i_fe_flush,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_oe,
  output logic [3:0]  o_sqi_data,
  input  logic [3:0]  i_sqi_data,
  output logic [15:0] o_fe_instr,
  output logic [15:0] o_fe_instr_pc,
  output logic        o_fe_valid,
  input  logic        i_fe_ready
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CAPTURE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q;
  logic [2:0]  beat_q, beat_d;
  logic [15:0] addr_q;
  logic [11:0] data_q;
  logic        inc_q;
  logic [3:0]  nib_d;
  logic [23:0] addr_byte;
  logic        buf_empty;
  logic        data_done;

  assign buf_empty   = !o_fe_valid || i_fe_ready;
  assign data_done   = (state_q == ST_DATA) && (beat_q == 3'd3);
  assign addr_byte   = {7'b0, addr_q, 1'b0};
  assign o_fe_pc_inc = inc_q && !i_fe_flush;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q + 3'd1;
    case (state_q)
      ST_IDLE: begin
        beat_d = 3'd0;
        if (phase_q == 2'd3 && buf_empty) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: if (beat_q == 3'd3) begin state_d = ST_CMD;   beat_d = 3'd0; end
      ST_CMD:     if (beat_q == 3'd1) begin state_d = ST_ADDR;  beat_d = 3'd0; end
      ST_ADDR:    if (beat_q == 3'd5) begin state_d = ST_DUMMY; beat_d = 3'd0; end
      ST_DUMMY:   if (beat_q == 3'd1) begin state_d = ST_DATA;  beat_d = 3'd0; end
      ST_DATA:    if (beat_q == 3'd3) begin state_d = ST_IDLE;  beat_d = 3'd0; end
      default: begin
        state_d = ST_IDLE;
        beat_d  = 3'd0;
      end
    endcase
    if (i_fe_flush) begin
      state_d = ST_IDLE;
      beat_d  = 3'd0;
    end
  end

  // SQI pins are registered, so the nibble is chosen from the next state/beat
  always_comb begin
    nib_d = 4'h0;
    if (state_d == ST_CMD) begin
      nib_d = (beat_d == 3'd1) ? 4'h3 : 4'h0;
    end else if (state_d == ST_ADDR) begin
      case (beat_d)
        3'd0:    nib_d = addr_byte[23:20];
        3'd1:    nib_d = addr_byte[19:16];
        3'd2:    nib_d = addr_byte[15:12];
        3'd3:    nib_d = addr_byte[11:8];
        3'd4:    nib_d = addr_byte[7:4];
        default: nib_d = addr_byte[3:0];
      endcase
    end
  end

  always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
    if (!i_pc_rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= 2'd0;
      beat_q        <= 3'd0;
      addr_q        <= 16'h0;
      data_q        <= 12'h0;
      inc_q         <= 1'b0;
      o_sqi_cs_n    <= 1'b1;
      o_sqi_oe      <= 1'b0;
      o_sqi_data    <= 4'h0;
      o_fe_instr    <= 16'h0;
      o_fe_instr_pc <= 16'h0;
      o_fe_valid    <= 1'b0;
    end else begin
      phase_q <= phase_q + 2'd1;
      state_q <= state_d;
      beat_q  <= beat_d;

      if (state_q == ST_CAPTURE) addr_q[{phase_q, 2'b00} +: 4] <= i_fe_pc;
      if (state_q == ST_DATA) data_q <= {data_q[7:0], i_sqi_data};

      // low byte arrives first, each byte high nibble first
      if (i_fe_flush) begin
        o_fe_valid <= 1'b0;
      end else if (data_done) begin
        o_fe_valid    <= 1'b1;
        o_fe_instr    <= {data_q[3:0], i_sqi_data, data_q[11:4]};
        o_fe_instr_pc <= addr_q;
      end else if (o_fe_valid && i_fe_ready) begin
        o_fe_valid <= 1'b0;
      end

      inc_q      <= (state_d == ST_CAPTURE);
      o_sqi_cs_n <= !(state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});
      o_sqi_oe   <= (state_d inside {ST_CMD, ST_ADDR});
      o_sqi_data <= nib_d;
    end
  end

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// tb/tb_idli_sqi_fetch_m.sv - randomized bench with PC block, SQI memory and transaction-level model
module tb_idli_sqi_fetch_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  fe_pc = 4'h0;
  logic        fe_pc_inc;
  logic        fe_flush = 1'b0;
  logic        cs_n, oe;
  logic [3:0]  sqo;
  logic [3:0]  sqi = 4'h0;
  logic [15:0] instr, ipc;
  logic        valid;
  logic        ready = 1'b0;

  always #5 clk = ~clk;

  idli_sqi_fetch_m dut (
    .i_pc_gck      (clk),
    .i_pc_rst_n    (rst_n),
    .i_fe_pc       (fe_pc),
    .o_fe_pc_inc   (fe_pc_inc),
    .i_fe_flush    (fe_flush),
    .o_sqi_cs_n    (cs_n),
    .o_sqi_oe      (oe),
    .o_sqi_data    (sqo),
    .i_sqi_data    (sqi),
    .o_fe_instr    (instr),
    .o_fe_instr_pc (ipc),
    .o_fe_valid    (valid),
    .i_fe_ready    (ready)
  );

  int n_pass = 0;
  int n_total = 0;

  // PC block
  logic [15:0] pc;
  int          inc_cnt;
  // transaction model: offset m_t from the first CAPTURE cycle
  int          cyc;
  bit          m_busy;
  int          m_t;
  logic [15:0] m_addr;
  bit          m_valid;
  logic [15:0] m_instr, m_ipc;
  // SQI memory
  int          slv_cnt;
  logic [3:0]  slv_log [8];
  logic [15:0] seed;
  // outputs sampled mid-cycle
  logic        s_inc, s_cs_n, s_oe, s_valid;
  logic [3:0]  s_data;
  logic [15:0] s_instr, s_ipc;

  logic [3:0]  exp_seq  [8] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  exp_a1234[6] = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};

  function automatic logic [15:0] mem(input logic [15:0] a);
    if (a == 16'h0) return 16'h1234;
    return (a * 16'h9e37) ^ seed;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [3:0] exp_data();
    logic [23:0] a24;
    a24 = {7'b0, m_addr, 1'b0};
    if (!m_busy) return 4'h0;
    if (m_t == 5) return 4'h3;
    if (m_t >= 6 && m_t <= 11) return a24[4*(11-m_t) +: 4];
    return 4'h0;
  endfunction

  task automatic compare();
    chk("pc_inc",   s_inc,   m_busy && m_t < 4 && !fe_flush);
    chk("cs_n",     s_cs_n,  !(m_busy && m_t >= 4 && m_t <= 17));
    chk("oe",       s_oe,    m_busy && m_t >= 4 && m_t <= 11);
    chk("sqi_data", s_data,  exp_data());
    chk("valid",    s_valid, m_valid);
    chk("instr",    s_instr, m_instr);
    chk("instr_pc", s_ipc,   m_ipc);
  endtask

  task automatic model_reset();
    cyc = 0; m_busy = 0; m_t = 0; m_addr = 0;
    m_valid = 0; m_instr = 0; m_ipc = 0;
    pc = 0; inc_cnt = 0; slv_cnt = 0;
  endtask

  task automatic drive_inputs();
    int j;
    logic [23:0] a;
    logic [15:0] w;
    fe_pc = pc[4*(cyc%4) +: 4];
    sqi = 4'($urandom);
    if (!cs_n) begin
      j = slv_cnt;
      slv_cnt++;
      if (j < 8) slv_log[j] = sqo;
      if (j >= 10 && j <= 13) begin
        a = {slv_log[2], slv_log[3], slv_log[4], slv_log[5], slv_log[6], slv_log[7]};
        w = mem(a[16:1]);
        case (j)
          10:      sqi = w[7:4];
          11:      sqi = w[3:0];
          12:      sqi = w[15:12];
          default: sqi = w[11:8];
        endcase
      end
    end else begin
      slv_cnt = 0;
    end
  endtask

  // one core cycle; entered and left just after a rising edge
  task automatic tick(input bit r, input bit f, input logic [15:0] tgt);
    ready = r;
    fe_flush = f;
    if (f) begin
      pc = tgt;
      inc_cnt = 0;
    end
    drive_inputs();
    @(negedge clk);
    #1;
    s_inc = fe_pc_inc; s_cs_n = cs_n; s_oe = oe; s_data = sqo;
    s_valid = valid; s_instr = instr; s_ipc = ipc;
    compare();
    if (s_inc) inc_cnt++;
    @(posedge clk);
    #1;
    if (f) begin
      m_busy = 0;
      m_valid = 0;
    end else begin
      if (m_valid && r) m_valid = 0;
      if (m_busy) begin
        if (m_t == 17) begin
          m_valid = 1; m_instr = mem(m_addr); m_ipc = m_addr; m_busy = 0;
        end else begin
          m_t++;
        end
      end else if (cyc % 4 == 3 && !m_valid) begin
        m_busy = 1; m_t = 0; m_addr = pc;
      end
    end
    if (cyc % 4 == 3) begin
      if (inc_cnt == 4) pc = pc + 16'h1;
      inc_cnt = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fe_flush = 1'b0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_oe", oe, 0);
    chk("rst_data", sqo, 0);
    chk("rst_inc", fe_pc_inc, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", ipc, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic first_fetch();
    for (int c = 0; c < 24; c++) begin
      tick(1, 0, 16'h0);
      chk("ff_inc", s_inc, (c >= 4 && c <= 7));
      chk("ff_cs_n", s_cs_n, !(c >= 8 && c <= 21));
      chk("ff_valid", s_valid, (c == 22));
      if (c == 22) begin
        chk("ff_instr", s_instr, 16'h1234);
        chk("ff_instr_pc", s_ipc, 16'h0000);
      end
    end
    for (int i = 0; i < 8; i++) chk("ff_sqi_seq", slv_log[i], exp_seq[i]);
  endtask

  task automatic wait_valid(input string nm, input bit r);
    int k;
    k = 0;
    tick(r, 0, 16'h0);
    while (!s_valid && k < 60) begin
      tick(r, 0, 16'h0);
      k++;
    end
    chk(nm, s_valid, 1);
  endtask

  initial begin
    int bad, h, first_inc;
    logic [15:0] tgt, w;
    seed = 16'($urandom);
    model_reset();
    do_reset();
    first_fetch();

    // cycle 24 is the first CAPTURE cycle of the next fetch: flush it
    tick(0, 1, 16'h1234);
    chk("flush_cap_inc", s_inc, 0);
    tick(0, 0, 16'h0);
    chk("flush_cap_idle_inc", s_inc, 0);

    wait_valid("pc1234_valid_seen", 0);
    chk("pc1234_instr_pc", s_ipc, 16'h1234);
    chk("pc1234_instr", s_instr, mem(16'h1234));
    chk("pc1234_pc_after", pc, 16'h1235);
    for (int i = 0; i < 6; i++) chk("pc1234_addr_nib", slv_log[2+i], exp_a1234[i]);

    w = s_instr;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 16'h0);
      if (!s_cs_n || s_inc || !s_valid || s_instr != w) bad++;
    end
    chk("backpressure_stall", bad, 0);

    h = cyc;
    tick(1, 0, 16'h0);
    first_inc = -1;
    for (int i = 0; i < 8 && first_inc < 0; i++) begin
      if (first_inc < 0) begin
        bad = cyc;
        tick(1, 0, 16'h0);
        if (s_inc) first_inc = bad;
      end
    end
    chk("capture_after_hs", first_inc, (h / 4 + 1) * 4);

    bad = 0;
    while (!(m_busy && m_t == 8) && bad < 60) begin
      tick(1, 0, 16'h0);
      bad++;
    end
    chk("addr_phase_reached", m_busy && m_t == 8, 1);
    tgt = 16'($urandom);
    tick(1, 1, tgt);
    tick(1, 0, 16'h0);
    chk("flush_addr_cs_n", s_cs_n, 1);
    chk("flush_addr_oe", s_oe, 0);
    chk("flush_addr_valid", s_valid, 0);
    wait_valid("refetch_valid_seen", 0);
    chk("refetch_instr_pc", s_ipc, tgt);
    chk("refetch_instr", s_instr, mem(tgt));

    while (cyc % 4 != 0) tick(0, 0, 16'h0);
    tick(0, 1, 16'($urandom));
    chk("flush_valid_hold", s_valid, 1);
    tick(0, 0, 16'h0);
    chk("flush_valid_clear", s_valid, 0);

    bad = 0;
    while (!(m_busy && m_t == 15) && bad < 80) begin
      tick(1, 0, 16'h0);
      bad++;
    end
    chk("data_phase_reached", m_busy && m_t == 15, 1);
    #2;
    chk("pre_reset_cs_n", cs_n, 0);
    chk("pre_reset_instr", instr, m_instr);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs_n", cs_n, 1);
    chk("async_rst_oe", oe, 0);
    chk("async_rst_valid", valid, 0);
    chk("async_rst_instr", instr, 0);
    chk("async_rst_instr_pc", ipc, 0);
    do_reset();
    first_fetch();

    for (int i = 0; i < 2500; i++) begin
      tick($urandom_range(0, 3) != 0,
           (cyc % 4 == 0) && ($urandom_range(0, 29) == 0),
           16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/idli_sqi_fetch_m.md
# idli_sqi_fetch_m

Instruction fetch stage directly downstream of the PC block. It captures the nibble-serial PC, requests the increment, and runs one SQI read of the 16-bit instruction at that PC. It then holds the instruction, with its PC, in a one-entry buffer for decode under a valid/ready handshake.

## Interface
Parameters: none.

- i_pc_gck  in  1  core clock; the top level drives SQI SCK from it
- i_pc_rst_n  in  1  reset, asynchronous, active-low
- i_fe_pc  in  4  current PC slice from the PC block; slice k is present at phase k
- o_fe_pc_inc  out  1  increment request to the PC block
- i_fe_flush  in  1  single-cycle abort pulse from execute on redirect
- o_sqi_cs_n  out  1  SQI chip select, active-low
- o_sqi_oe  out  1  1 = fetch drives the SQI data pins
- o_sqi_data  out  4  SQI data out
- i_sqi_data  in  4  SQI data in
- o_fe_instr  out  16  buffered instruction
- o_fe_instr_pc  out  16  PC of the buffered instruction
- o_fe_valid  out  1  buffer full
- i_fe_ready  in  1  decode accepts the buffer this cycle

## Operation
Phase counter:
- 2-bit phase counter, 0 out of reset, increments every cycle and wraps 3→0.
- Aligned with the PC rotation: i_fe_pc carries PC[4k+3:4k] at phase k.

State machine: IDLE, CAPTURE (4 cycles), CMD (2), ADDR (6), DUMMY (2), DATA (4). A 3-bit beat counter tracks position within each state.

- IDLE→CAPTURE when phase==3, the buffer is empty, and i_fe_flush=0. The buffer is empty when o_fe_valid=0 or a valid&&ready handshake occurs this cycle. CAPTURE therefore always spans phases 0..3.
- CAPTURE:
  - o_fe_pc_inc=1.
  - Latch i_fe_pc into addr_q[4k+3:4k] at phase k.
  - After 4 cycles the PC block holds PC+1.
- CMD:
  - cs_n=0, oe=1.
  - Drive 0x0, then 0x3 (READ).
- ADDR:
  - cs_n=0, oe=1.
  - Drive the 24-bit byte address {7'b0, addr_q, 1'b0}, MSN first: bits [23:20] first, [3:0] last.
- DUMMY: cs_n=0, oe=0, o_sqi_data=0.
- DATA:
  - cs_n=0, oe=0.
  - Sample i_sqi_data as n0..n3.
  - The even byte is the instruction's low byte, and each byte arrives MSN first. On the last beat, o_fe_instr←{n2,n3,n0,n1}, o_fe_instr_pc←addr_q, o_fe_valid←1.
  - Next state is IDLE.
- Outside CMD..DATA: cs_n=1, oe=0, o_sqi_data=0.
- o_fe_valid clears on a valid&&ready handshake. o_fe_instr and o_fe_instr_pc hold their values until the next DATA completion.
- Flush, in any state:
  - Next state is IDLE and o_fe_valid clears.
  - o_fe_pc_inc is forced to 0 in the flush cycle.
  - Any partially received data is discarded.
  - Flush has priority over handshake and DATA completion.
- Execute asserts flush only at phase 0, concurrent with the first cycle of its 4-cycle PC redirect.

## Timing
- Reset values:
  - State IDLE; phase 0; beat counter 0.
  - o_sqi_cs_n=1, o_sqi_oe=0, o_sqi_data=0.
  - o_fe_pc_inc=0, o_fe_valid=0, o_fe_instr=0, o_fe_instr_pc=0.
  - addr_q=0.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous), and cs_n rises without waiting for a clock.
- All outputs are decoded from registered state, beat counter, and buffer. No combinational path from i_sqi_data or i_fe_ready to any output.
- o_fe_pc_inc has a combinational path from i_fe_flush only.
- First fetch after reset:
  - Cycles 0-3: IDLE.
  - Cycles 4-7: CAPTURE.
  - Cycles 8-9: CMD.
  - Cycles 10-15: ADDR.
  - Cycles 16-17: DUMMY.
  - Cycles 18-21: DATA.
  - Cycle 22: o_fe_valid=1.
- Transaction length: capture to valid is 18 cycles.
- Steady state with ready always high: one instruction per 20 cycles, with the next CAPTURE starting at the first phase 0 after the handshake.
- cs_n is high for at least 4 cycles between transactions.
- Backpressure: while o_fe_valid=1 and ready=0, stay in IDLE with no increment and cs_n=1.

## Test plan
- Reset, PC=0; memory returns nibbles 3,4,1,2 → o_fe_pc_inc high exactly cycles 4-7; SQI sequence 0,3,0,0,0,0,0,0; o_fe_instr=0x1234, o_fe_instr_pc=0x0000, o_fe_valid rises at cycle 22.
- PC block holding 0x1234 → address nibbles 0,0,2,4,6,8; o_fe_instr_pc=0x1234; PC block reads 0x1235 after capture.
- Ready held low 30 cycles after valid → no CAPTURE, cs_n=1, o_fe_pc_inc=0; instr and valid stable. Ready high → handshake, CAPTURE begins at the next phase 0.
- Flush during ADDR → cs_n=1 and oe=0 the next cycle, o_fe_valid stays 0, the aborted data is never presented; a fresh fetch follows.
- Flush while valid=1 and ready=0 → valid clears the next cycle. Flush coincident with the first CAPTURE cycle → o_fe_pc_inc=0 that cycle, state returns to IDLE.
- Async reset asserted mid-DATA → cs_n=1, valid=0, outputs reset without a clock edge; after release the first fetch timing repeats exactly.
